// File: rtl/multicycle_controller_if.sv
// Control/status bundle between the multicycle controller (master) and its
// shared-ALU, shared-memory datapath (slave).
interface multicycle_controller_if #(
    parameter int CNT_W = 32
);
    logic [6:0]       opc;
    logic [2:0]       f3;
    logic [6:0]       f7;
    logic             zero;
    logic             mem_ready;

    logic             pc_write;
    logic             adr_src;
    logic             mem_write;
    logic             ir_write;
    logic             reg_write;
    logic [1:0]       result_src;
    logic [1:0]       alu_src_a;
    logic [1:0]       alu_src_b;
    logic [2:0]       alu_op;
    logic [2:0]       imm_src;
    logic [3:0]       state_out;
    logic             instr_done;
    logic [CNT_W-1:0] retired;
    logic             illegal;

    modport master (
        input  opc, f3, f7, zero, mem_ready,
        output pc_write, adr_src, mem_write, ir_write, reg_write,
               result_src, alu_src_a, alu_src_b, alu_op, imm_src,
               state_out, instr_done, retired, illegal
    );

    modport slave (
        output opc, f3, f7, zero, mem_ready,
        input  pc_write, adr_src, mem_write, ir_write, reg_write,
               result_src, alu_src_a, alu_src_b, alu_op, imm_src,
               state_out, instr_done, retired, illegal
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle FSM controller for the RV32I-subset core with retired-instruction counter.
// Define MULTICYCLE_CTRL_ILLEGAL_TRAP_EN to trap illegal instructions into HALT.
module multicycle_controller #(
    parameter int CNT_W = 32
) (
    input logic                     clk,
    input logic                     rst,
    multicycle_controller_if.master bus
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10,
        LUI      = 4'd11,
        HALT     = 4'd12
    } state_e;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [6:0] OPC_LW  = 7'd3;
    localparam logic [6:0] OPC_SW  = 7'd35;
    localparam logic [6:0] OPC_R   = 7'd51;
    localparam logic [6:0] OPC_I   = 7'd19;
    localparam logic [6:0] OPC_BR  = 7'd99;
    localparam logic [6:0] OPC_JAL = 7'd111;
    localparam logic [6:0] OPC_LUI = 7'd55;

`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    localparam state_e ILLEGAL_NEXT = HALT;
`else
    localparam state_e ILLEGAL_NEXT = FETCH;
`endif

    state_e           state;
    state_e           state_next;
    logic [CNT_W-1:0] retired_q;
    logic             legal;
    logic [2:0]       r_alu_op;
    logic [2:0]       i_alu_op;
    logic             pc_write_raw;
    logic             ir_write_raw;
    logic             mem_write_raw;
    logic             reg_write_raw;
    logic             done_raw;

    always_comb begin
        legal = 1'b0;
        case (bus.opc)
            OPC_LW, OPC_SW:   legal = (bus.f3 == 3'd2);
            OPC_R:            legal = ((bus.f7 == 7'd0) && (bus.f3 inside {3'd0, 3'd7, 3'd6, 3'd2}))
                                   || ((bus.f7 == 7'd32) && (bus.f3 == 3'd0));
            OPC_I:            legal = bus.f3 inside {3'd0, 3'd6, 3'd2};
            OPC_BR:           legal = bus.f3 inside {3'd0, 3'd1};
            OPC_JAL, OPC_LUI: legal = 1'b1;
            default:          legal = 1'b0;
        endcase
    end

    // ALU op decode; only reached for instructions that already passed the legality check.
    always_comb begin
        r_alu_op = ALU_ADD;
        i_alu_op = ALU_ADD;
        case (bus.f3)
            3'd0:    r_alu_op = bus.f7[5] ? ALU_SUB : ALU_ADD;
            3'd7:    r_alu_op = ALU_AND;
            3'd6:    r_alu_op = ALU_OR;
            3'd2:    r_alu_op = ALU_SLT;
            default: r_alu_op = ALU_ADD;
        endcase
        case (bus.f3)
            3'd6:    i_alu_op = ALU_OR;
            3'd2:    i_alu_op = ALU_SLT;
            default: i_alu_op = ALU_ADD;
        endcase
    end

    always_comb begin
        // NOTE: every output gets a default before the case, so no path can infer a latch.
        state_next     = state;
        pc_write_raw   = 1'b0;
        ir_write_raw   = 1'b0;
        mem_write_raw  = 1'b0;
        reg_write_raw  = 1'b0;
        done_raw       = 1'b0;
        bus.adr_src    = 1'b0;
        bus.result_src = 2'b00;
        bus.alu_src_a  = 2'b00;
        bus.alu_src_b  = 2'b00;
        bus.alu_op     = ALU_ADD;
        bus.imm_src    = IMM_I;

        case (state)
            FETCH: begin
                bus.alu_src_b  = 2'b10;
                bus.result_src = 2'b10;
                pc_write_raw   = bus.mem_ready;
                ir_write_raw   = bus.mem_ready;
                if (bus.mem_ready) state_next = DECODE;
            end
            DECODE: begin
                bus.alu_src_a = 2'b01;
                bus.alu_src_b = 2'b01;
                bus.imm_src   = (bus.opc == OPC_JAL) ? IMM_J : IMM_B;
                if (!legal) begin
                    state_next = ILLEGAL_NEXT;
                end else begin
                    case (bus.opc)
                        OPC_LW, OPC_SW: state_next = MEMADR;
                        OPC_R:          state_next = EXECR;
                        OPC_I:          state_next = EXECI;
                        OPC_BR:         state_next = BRANCH;
                        OPC_JAL:        state_next = JAL;
                        OPC_LUI:        state_next = LUI;
                        default:        state_next = FETCH;
                    endcase
                end
            end
            MEMADR: begin
                bus.alu_src_a = 2'b10;
                bus.alu_src_b = 2'b01;
                bus.imm_src   = (bus.opc == OPC_SW) ? IMM_S : IMM_I;
                state_next    = (bus.opc == OPC_SW) ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                bus.adr_src = 1'b1;
                if (bus.mem_ready) state_next = MEMWB;
            end
            MEMWB: begin
                bus.result_src = 2'b01;
                reg_write_raw  = 1'b1;
                done_raw       = 1'b1;
                state_next     = FETCH;
            end
            MEMWRITE: begin
                bus.adr_src   = 1'b1;
                mem_write_raw = 1'b1;
                if (bus.mem_ready) begin
                    done_raw   = 1'b1;
                    state_next = FETCH;
                end
            end
            EXECR: begin
                bus.alu_src_a = 2'b10;
                bus.alu_op    = r_alu_op;
                state_next    = ALUWB;
            end
            EXECI: begin
                bus.alu_src_a = 2'b10;
                bus.alu_src_b = 2'b01;
                bus.alu_op    = i_alu_op;
                state_next    = ALUWB;
            end
            ALUWB: begin
                reg_write_raw = 1'b1;
                done_raw      = 1'b1;
                state_next    = FETCH;
            end
            BRANCH: begin
                bus.alu_src_a = 2'b10;
                bus.alu_op    = ALU_SUB;
                pc_write_raw  = ((bus.f3 == 3'd0) && bus.zero) || ((bus.f3 == 3'd1) && !bus.zero);
                done_raw      = 1'b1;
                state_next    = FETCH;
            end
            JAL: begin
                bus.alu_src_a = 2'b01;
                bus.alu_src_b = 2'b10;
                pc_write_raw  = 1'b1;
                state_next    = ALUWB;
            end
            LUI: begin
                bus.imm_src    = IMM_U;
                bus.result_src = 2'b11;
                reg_write_raw  = 1'b1;
                done_raw       = 1'b1;
                state_next     = FETCH;
            end
            HALT:    state_next = HALT;
            default: state_next = FETCH;
        endcase
    end

    // A reset cycle abandons the current instruction: no architectural write, no retire.
    assign bus.pc_write   = pc_write_raw & ~rst;
    assign bus.ir_write   = ir_write_raw & ~rst;
    assign bus.mem_write  = mem_write_raw & ~rst;
    assign bus.reg_write  = reg_write_raw & ~rst;
    assign bus.instr_done = done_raw & ~rst;
    assign bus.state_out  = state;
    assign bus.retired    = retired_q;

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state     <= FETCH;
            retired_q <= '0;
        end else begin
            state <= state_next;
            if (done_raw) retired_q <= retired_q + CNT_W'(1);
        end
    end

`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    logic illegal_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_q <= 1'b0;
        end else if ((state == DECODE) && !legal) begin
            illegal_q <= 1'b1;
        end
    end

    assign bus.illegal = illegal_q;
`else
    assign bus.illegal = 1'b0;
`endif
endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: a per-instruction phase-path model
// checked every cycle, plus directed instruction vectors with literal expectations.
module tb_multicycle_controller;
    localparam int CNT_W = 4;

    typedef enum int {K_LW, K_SW, K_R, K_I, K_BR, K_JAL, K_LUI, K_BAD} kind_e;

    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [2:0] imm_src;
    } ctrl_t;

    typedef struct packed {
        bit               valid;
        bit               halted;
        bit               ill;
        int               idx;
        logic [CNT_W-1:0] ret;
    } mdl_t;

    localparam int R_F3 [5] = '{0, 0, 7, 6, 2};
    localparam int R_F7 [5] = '{0, 32, 0, 0, 0};
    localparam int R_OP [5] = '{0, 1, 2, 3, 4};
    localparam int I_F3 [3] = '{0, 6, 2};
    localparam int I_OP [3] = '{0, 3, 4};

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    mdl_t mdl = '0;

    logic [3:0] rec_state [16];
    logic       rec_pc    [16];
    logic       rec_ir    [16];
    logic       rec_reg   [16];
    logic       rec_mem   [16];
    logic       rec_done  [16];
    logic [1:0] rec_res   [16];
    logic [2:0] rec_alu   [16];
    logic [2:0] rec_imm   [16];

    multicycle_controller_if #(.CNT_W(CNT_W)) bus ();

    multicycle_controller #(.CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int r_index(input logic [2:0] f3v, input logic [6:0] f7v);
        for (int i = 0; i < 5; i++)
            if (int'(f3v) == R_F3[i] && int'(f7v) == R_F7[i]) return i;
        return -1;
    endfunction

    function automatic int i_index(input logic [2:0] f3v);
        for (int i = 0; i < 3; i++)
            if (int'(f3v) == I_F3[i]) return i;
        return -1;
    endfunction

    function automatic kind_e kind_of(input logic [6:0] o, input logic [2:0] f3v, input logic [6:0] f7v);
        case (o)
            7'd3:    return (f3v == 3'd2) ? K_LW : K_BAD;
            7'd35:   return (f3v == 3'd2) ? K_SW : K_BAD;
            7'd51:   return (r_index(f3v, f7v) >= 0) ? K_R : K_BAD;
            7'd19:   return (i_index(f3v) >= 0) ? K_I : K_BAD;
            7'd99:   return (f3v <= 3'd1) ? K_BR : K_BAD;
            7'd111:  return K_JAL;
            7'd55:   return K_LUI;
            default: return K_BAD;
        endcase
    endfunction

    // Sequence of spec state numbers each instruction kind walks through; -1 ends it.
    function automatic int path_phase(input kind_e k, input int idx);
        int p [6];
        case (k)
            K_LW:    p = '{0, 1, 2, 3, 4, -1};
            K_SW:    p = '{0, 1, 2, 5, -1, -1};
            K_R:     p = '{0, 1, 6, 8, -1, -1};
            K_I:     p = '{0, 1, 7, 8, -1, -1};
            K_BR:    p = '{0, 1, 9, -1, -1, -1};
            K_JAL:   p = '{0, 1, 10, 8, -1, -1};
            K_LUI:   p = '{0, 1, 11, -1, -1, -1};
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
            default: p = '{0, 1, 12, -1, -1, -1};
`else
            default: p = '{0, 1, -1, -1, -1, -1};
`endif
        endcase
        if (idx < 0 || idx > 5) return -1;
        return p[idx];
    endfunction

    function automatic bit waits_mem(input int ph);
        return (ph == 0) || (ph == 3) || (ph == 5);
    endfunction

    function automatic mdl_t model_step(input mdl_t m, input logic r, input logic mr, input kind_e k);
        mdl_t n = m;
        if (r) begin
            n = '0;
            n.valid = 1'b1;
            return n;
        end
        if (!m.valid || m.halted) return m;
        if (waits_mem(path_phase(k, m.idx)) && !mr) return m;
        n.idx = m.idx + 1;
        if (path_phase(k, n.idx) == -1) begin
            n.idx = 0;
            if (k != K_BAD) n.ret = m.ret + 1'b1;
        end else if (path_phase(k, n.idx) == 12) begin
            n.halted = 1'b1;
            n.ill    = 1'b1;
        end
        return n;
    endfunction

    function automatic bit exp_done(input mdl_t m, input logic r, input logic mr, input kind_e k);
        if (!m.valid || m.halted || r || k == K_BAD) return 1'b0;
        if (waits_mem(path_phase(k, m.idx)) && !mr) return 1'b0;
        return path_phase(k, m.idx + 1) == -1;
    endfunction

    function automatic ctrl_t model_ctrl(input int ph, input logic [6:0] o, input logic [2:0] f3v,
                                         input logic [6:0] f7v, input logic z, input logic mr,
                                         input logic r);
        ctrl_t c = '0;
        int    ri = r_index(f3v, f7v);
        int    ii = i_index(f3v);
        case (ph)
            0:  begin c.alu_src_b = 2'd2; c.result_src = 2'd2; c.pc_write = mr; c.ir_write = mr; end
            1:  begin c.alu_src_a = 2'd1; c.alu_src_b = 2'd1; c.imm_src = (o == 7'd111) ? 3'd3 : 3'd2; end
            2:  begin c.alu_src_a = 2'd2; c.alu_src_b = 2'd1; c.imm_src = (o == 7'd35) ? 3'd1 : 3'd0; end
            3:  c.adr_src = 1'b1;
            4:  begin c.result_src = 2'd1; c.reg_write = 1'b1; end
            5:  begin c.adr_src = 1'b1; c.mem_write = 1'b1; end
            6:  begin c.alu_src_a = 2'd2; c.alu_op = (ri < 0) ? 3'd0 : 3'(R_OP[ri]); end
            7:  begin c.alu_src_a = 2'd2; c.alu_src_b = 2'd1; c.alu_op = (ii < 0) ? 3'd0 : 3'(I_OP[ii]); end
            8:  c.reg_write = 1'b1;
            9:  begin c.alu_src_a = 2'd2; c.alu_op = 3'd1; c.pc_write = (f3v == 3'd0) ? z : ~z; end
            10: begin c.alu_src_a = 2'd1; c.alu_src_b = 2'd2; c.pc_write = 1'b1; end
            11: begin c.imm_src = 3'd4; c.result_src = 2'd3; c.reg_write = 1'b1; end
            default: c = '0;
        endcase
        if (r) begin
            c.pc_write  = 1'b0;
            c.ir_write  = 1'b0;
            c.mem_write = 1'b0;
            c.reg_write = 1'b0;
        end
        return c;
    endfunction

    always @(posedge clk)
        mdl <= model_step(mdl, rst, bus.mem_ready, kind_of(bus.opc, bus.f3, bus.f7));

    task automatic compare_cycle();
        kind_e k  = kind_of(bus.opc, bus.f3, bus.f7);
        int    ph = mdl.halted ? 12 : path_phase(k, mdl.idx);
        ctrl_t e  = model_ctrl(ph, bus.opc, bus.f3, bus.f7, bus.zero, bus.mem_ready, rst);
        check("state_out",  bus.state_out, ph);
        check("pc_write",   bus.pc_write, e.pc_write);
        check("adr_src",    bus.adr_src, e.adr_src);
        check("mem_write",  bus.mem_write, e.mem_write);
        check("ir_write",   bus.ir_write, e.ir_write);
        check("reg_write",  bus.reg_write, e.reg_write);
        check("result_src", bus.result_src, e.result_src);
        check("alu_src_a",  bus.alu_src_a, e.alu_src_a);
        check("alu_src_b",  bus.alu_src_b, e.alu_src_b);
        check("alu_op",     bus.alu_op, e.alu_op);
        check("imm_src",    bus.imm_src, e.imm_src);
        check("instr_done", bus.instr_done, exp_done(mdl, rst, bus.mem_ready, k));
        check("retired",    bus.retired, mdl.ret);
        check("illegal",    bus.illegal, mdl.ill);
    endtask

    always @(negedge clk)
        if (mdl.valid) compare_cycle();

    // Runs one instruction for ncyc cycles; mem_ready is low for fs FETCH cycles and
    // for ms cycles of the memory-access state that starts three cycles after fetch.
    task automatic run_instr(input string name, input logic [6:0] o, input logic [2:0] f3v,
                             input logic [6:0] f7v, input logic zv, input int fs, input int ms,
                             input int ncyc, input int exp_dn, input int exp_end);
        int n_dn = 0;
        bus.opc  = o;
        bus.f3   = f3v;
        bus.f7   = f7v;
        bus.zero = zv;
        for (int c = 0; c < ncyc; c++) begin
            bus.mem_ready = !((c < fs) || (c >= fs + 3 && c < fs + 3 + ms));
            @(negedge clk);
            rec_state[c] = bus.state_out;
            rec_pc[c]    = bus.pc_write;
            rec_ir[c]    = bus.ir_write;
            rec_reg[c]   = bus.reg_write;
            rec_mem[c]   = bus.mem_write;
            rec_done[c]  = bus.instr_done;
            rec_res[c]   = bus.result_src;
            rec_alu[c]   = bus.alu_op;
            rec_imm[c]   = bus.imm_src;
            if (bus.instr_done) n_dn++;
            @(posedge clk);
            #1;
        end
        bus.mem_ready = 1'b0;
        check({name, " end state"}, bus.state_out, exp_end);
        check({name, " instr_done count"}, n_dn, exp_dn);
        check({name, " instr_done on last cycle"}, rec_done[ncyc-1], exp_dn);
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic run_illegal(input string name, input logic [6:0] o, input logic [2:0] f3v,
                               input logic [6:0] f7v);
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
        run_instr(name, o, f3v, f7v, 1'b0, 0, 0, 2, 0, 12);
        bus.mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check({name, " halted state"}, bus.state_out, 12);
        check({name, " illegal sticky"}, bus.illegal, 1);
        check({name, " retired frozen"}, bus.retired, 1);
        check({name, " no pc_write in HALT"}, bus.pc_write, 0);
        reset_pulse();
        check({name, " illegal cleared"}, bus.illegal, 0);
        run_instr({name, " lui after reset"}, 7'd55, 3'd0, 7'd0, 1'b0, 0, 0, 3, 1, 0);
        check({name, " retired after lui"}, bus.retired, 1);
`else
        run_instr(name, o, f3v, f7v, 1'b0, 0, 0, 2, 0, 0);
        check({name, " illegal tied low"}, bus.illegal, 0);
        check({name, " retired unchanged"}, bus.retired, 1);
`endif
    endtask

    initial begin
        int add_seq [4] = '{0, 1, 6, 8};
        int r_f3 [4]    = '{0, 7, 6, 2};
        int r_f7 [4]    = '{32, 0, 0, 0};
        int r_exp [4]   = '{1, 2, 3, 4};
        int i_f3 [3]    = '{0, 6, 2};
        int i_exp [3]   = '{0, 3, 4};
        int n_ir;
        int n_mw;

        bus.opc       = 7'd0;
        bus.f3        = 3'd0;
        bus.f7        = 7'd0;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset state", bus.state_out, 0);
        check("reset retired", bus.retired, 0);
        check("reset illegal", bus.illegal, 0);

        run_instr("add", 7'd51, 3'd0, 7'd0, 1'b0, 0, 0, 4, 1, 0);
        for (int c = 0; c < 4; c++) begin
            check($sformatf("add state[%0d]", c), rec_state[c], add_seq[c]);
            check($sformatf("add reg_write[%0d]", c), rec_reg[c], (c == 3) ? 1 : 0);
        end
        check("add alu_op in EXECR", rec_alu[2], 0);
        check("add retired", bus.retired, 1);

        run_instr("lw stalled", 7'd3, 3'd2, 7'd0, 1'b0, 2, 3, 10, 1, 0);
        n_ir = 0;
        for (int c = 0; c < 10; c++) if (rec_ir[c]) n_ir++;
        check("lw ir_write pulses", n_ir, 1);
        check("lw result_src in MEMWB", rec_res[9], 1);
        check("lw MEMWB state", rec_state[9], 4);

        run_instr("beq taken", 7'd99, 3'd0, 7'd0, 1'b1, 0, 0, 3, 1, 0);
        check("beq taken pc_write", rec_pc[2], 1);
        check("beq alu_op", rec_alu[2], 1);
        run_instr("beq not taken", 7'd99, 3'd0, 7'd0, 1'b0, 0, 0, 3, 1, 0);
        check("beq not taken pc_write", rec_pc[2], 0);
        run_instr("bne taken", 7'd99, 3'd1, 7'd0, 1'b0, 0, 0, 3, 1, 0);
        check("bne taken pc_write", rec_pc[2], 1);

        run_instr("jal", 7'd111, 3'd0, 7'd0, 1'b0, 0, 0, 4, 1, 0);
        check("jal decode imm_src", rec_imm[1], 3);
        check("jal pc_write in JAL", rec_pc[2], 1);
        check("jal reg_write in ALUWB", rec_reg[3], 1);

        for (int i = 0; i < 4; i++) begin
            run_instr($sformatf("R f3=%0d f7=%0d", r_f3[i], r_f7[i]), 7'd51, 3'(r_f3[i]),
                      7'(r_f7[i]), 1'b0, 0, 0, 4, 1, 0);
            check($sformatf("R f3=%0d alu_op", r_f3[i]), rec_alu[2], r_exp[i]);
        end
        for (int i = 0; i < 3; i++) begin
            run_instr($sformatf("I f3=%0d", i_f3[i]), 7'd19, 3'(i_f3[i]), 7'd0, 1'b0, 0, 0, 4, 1, 0);
            check($sformatf("I f3=%0d alu_op", i_f3[i]), rec_alu[2], i_exp[i]);
            check($sformatf("I f3=%0d imm_src", i_f3[i]), rec_imm[2], 0);
        end

        run_instr("sw stalled", 7'd35, 3'd2, 7'd0, 1'b0, 1, 2, 7, 1, 0);
        n_mw = 0;
        for (int c = 0; c < 7; c++) if (rec_mem[c]) n_mw++;
        check("sw mem_write cycles", n_mw, 3);
        check("sw MEMADR imm_src", rec_imm[3], 1);

        run_instr("lui", 7'd55, 3'd0, 7'd0, 1'b0, 0, 0, 3, 1, 0);
        check("lui imm_src", rec_imm[2], 4);
        check("lui result_src", rec_res[2], 3);

        // Reset while a store is waiting on memory.
        bus.opc       = 7'd35;
        bus.f3        = 3'd2;
        bus.mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        check("sw wait state", bus.state_out, 5);
        check("sw wait mem_write", bus.mem_write, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst in MEMWRITE mem_write", bus.mem_write, 0);
        check("rst in MEMWRITE instr_done", bus.instr_done, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst in MEMWRITE next state", bus.state_out, 0);
        check("rst in MEMWRITE retired", bus.retired, 0);

        // 17 retirements wrap a 4-bit counter to 1.
        for (int i = 0; i < 17; i++)
            run_instr($sformatf("lui wrap %0d", i), 7'd55, 3'd0, 7'd0, 1'b0, 0, 0, 3, 1, 0);
        check("retired wrap", bus.retired, 1);

        run_illegal("illegal R funct", 7'd51, 3'd1, 7'd0);
        run_illegal("illegal opc 0x7F", 7'h7F, 3'd0, 7'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: time limit reached, failures so far %0d", n_fail);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multicycle FSM controller for the RV32I-subset core: add, sub, and, or, slt, lw, addi, ori, slti, sw, jal, beq, bne, lui.
- Sequences a shared-ALU, shared-memory datapath through fetch, decode, execute, memory and writeback.
- Stalls on a memory ready handshake and keeps a retired-instruction counter.
- ALU op and immediate-select encodings are identical to those of the single-cycle core controller.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- opc  in  7  latched IR[6:0]
- f3  in  3  latched IR[14:12]
- f7  in  7  latched IR[31:25]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- pc_write  out  1  PC register load enable
- adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_write  out  1  memory write strobe
- ir_write  out  1  IR and OldPC load enable
- reg_write  out  1  register file write enable
- result_src  out  2  00 ALUOut, 01 MemData, 10 ALUResult, 11 ImmExt
- alu_src_a  out  2  00 PC, 01 OldPC, 10 RS1
- alu_src_b  out  2  00 RS2, 01 ImmExt, 10 constant 4
- alu_op  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT
- imm_src  out  3  000 I, 001 S, 010 B, 011 J, 100 U
- state_out  out  4  current state, for debug
- instr_done  out  1  one-cycle pulse on the last cycle of a retired instruction
- retired  out  CNT_W  count of retired instructions
- illegal  out  1  sticky illegal-instruction flag

Behaviour:
- State is registered; outputs decode combinationally from state, opc/f3/f7, zero and mem_ready.
- Any output not listed for a state is 0 in that state.
- Reset: the edge with rst=1 sets state=FETCH (0), retired=0 and illegal=0.
- While rst=1, pc_write, ir_write, mem_write and reg_write are forced to 0.
- Reset mid-instruction abandons it with no write and no count.
- FETCH (0): adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=ADD, result_src=10.
  - pc_write = ir_write = mem_ready.
  - mem_ready=0: stay in FETCH. mem_ready=1: go to DECODE.
- DECODE (1): alu_src_a=01, alu_src_b=01, alu_op=ADD, imm_src=J if opc=111 else B. Next state:
  - opc 3 or 35 → MEMADR
  - opc 51 → EXECR
  - opc 19 → EXECI
  - opc 99 → BRANCH
  - opc 111 → JAL
  - opc 55 → LUI
  - otherwise → illegal handling
- Legality check: R-type legal only for f3/f7 pairs 0/0, 0/32, 7/0, 6/0, 2/0.
  - I-type legal for f3 ∈ {0, 6, 2}; lw and sw need f3=2; branches need f3 ∈ {0, 1}.
- MEMADR (2): alu_src_a=10, alu_src_b=01, alu_op=ADD, imm_src=I for lw, S for sw. Next: MEMREAD (lw) or MEMWRITE (sw).
- MEMREAD (3): adr_src=1. Hold until mem_ready=1, then MEMWB.
- MEMWB (4): result_src=01, reg_write=1 → FETCH.
- MEMWRITE (5): adr_src=1, mem_write=1, held high until mem_ready=1 → FETCH.
- EXECR (6): alu_src_a=10, alu_src_b=00, alu_op from f3/f7: 0/0 ADD, 0/32 SUB, 7 AND, 6 OR, 2 SLT → ALUWB.
- EXECI (7): alu_src_a=10, alu_src_b=01, imm_src=I, alu_op from f3: 0 ADD, 6 OR, 2 SLT → ALUWB.
- ALUWB (8): result_src=00, reg_write=1 → FETCH.
- BRANCH (9): alu_src_a=10, alu_src_b=00, alu_op=SUB, result_src=00.
  - pc_write = (f3=0 & zero) | (f3=1 & ~zero) → FETCH.
- JAL (10): alu_src_a=01, alu_src_b=10, alu_op=ADD, result_src=00, pc_write=1 → ALUWB, which writes OldPC+4 to rd.
- LUI (11): imm_src=U, result_src=11, reg_write=1 → FETCH.
- HALT (12): all enables 0; held until rst.
- instr_done is 1 on the cycle a state transitions to FETCH from MEMWB, MEMWRITE (with mem_ready), ALUWB, BRANCH or LUI.
  - retired increments on those same edges and wraps modulo 2^CNT_W.
- Latencies with mem_ready always 1, counted in cycles:
  - lw 5, sw 4, R/I-type 4, jal 4, beq/bne 3, lui 3.

Optional Feature:
- Macro: MULTICYCLE_CTRL_ILLEGAL_TRAP_EN.
- Defined: an illegal opcode or funct in DECODE → HALT; illegal=1 from the next cycle, sticky until rst; retired is frozen.
- Undefined: an illegal instruction goes DECODE → FETCH as a NOP; no write, no count, no instr_done; illegal is tied to 0.

Test Plan:
- add x3,x1,x2 (opc 51, f3 0, f7 0), mem_ready=1 → states 0,1,6,8,0; alu_op=000 in EXECR; reg_write=1 only in ALUWB; retired 0→1.
- lw with mem_ready low for 2 cycles in FETCH and 3 in MEMREAD → ir_write pulses exactly once; 10 cycles total; result_src=01 in MEMWB.
- beq with zero=1, then beq with zero=0, then bne with zero=0 → pc_write in BRANCH: 1, 0, 1; each takes 3 cycles; alu_op=001.
- jal → DECODE imm_src=011; pc_write=1 in JAL; reg_write=1 in the following ALUWB; 4 cycles.
- rst=1 asserted in MEMWRITE while mem_ready=0 → next state FETCH, mem_write=0 that cycle, retired=0.
- opc=0x7F → with the macro: state 12, illegal=1, no further enables, retired frozen; without the macro: back to FETCH after 2 cycles, retired unchanged.
